regfile_writeback: RTL and testbench

Write-side controller for the 32×32 register file in the multi-cycle RISC-V core. It takes a writeback request from the control FSM and selects the result source: ALU result, load data, PC+4 or immediate. For loads it waits for memory, then byte/halfword-selects and sign/zero-extends the data. It drives the register file write port (`da`, `din`, `web`) for exactly one cycle and suppresses writes to x0.

---
 rtl/regfile_writeback.sv | 194 +++++++++++++++++++
 tb/tb_regfile_writeback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register file write-side controller: source select, load extend, x0 guard.
// Optional forwarding outputs enabled by REGFILE_WB_FWD_EN.
module regfile_writeback #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_req,
  input  logic [1:0]      wb_sel,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_valid,
  output logic [4:0]      da,
  output logic [XLEN-1:0] din,
  output logic            web,
  output logic            wb_busy,
  output logic            wb_done,
  output logic            wb_err,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT,
    S_ERR
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  state_t state_q, state_d;

  logic [4:0] rd_q;
  logic [2:0] f3_q;
  logic [1:0] alo_q;

  logic [4:0]      da_q, da_d;
  logic [XLEN-1:0] din_q, din_d;
  logic            web_q, web_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] src;
  logic [XLEN-1:0] ext;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            load_ok;
  logic            go_commit;
  logic            go_err;
  logic [4:0]      c_rd;
  logic [XLEN-1:0] c_data;

  always_comb begin
    load_ok = 1'b0;
    unique case (funct3)
      3'b000,
      3'b100: load_ok = 1'b1;
      3'b001,
      3'b101: load_ok = ~addr_lo[0];
      3'b010: load_ok = (addr_lo == 2'b00);
      default: load_ok = 1'b0;
    endcase
  end

  always_comb begin
    src = alu_result;
    unique case (wb_sel)
      SEL_ALU:  src = alu_result;
      SEL_LOAD: src = alu_result;
      SEL_PC4:  src = pc_plus4;
      SEL_IMM:  src = imm;
      default:  src = alu_result;
    endcase
  end

  always_comb begin
    byte_v = mem_rdata[{alo_q, 3'b000} +: 8];
    half_v = mem_rdata[{alo_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'b000:  ext = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  ext = {{(XLEN-16){half_v[15]}}, half_v};
      3'b100:  ext = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  ext = {{(XLEN-16){1'b0}}, half_v};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (wb_req) begin
          if (wb_sel != SEL_LOAD) state_d = S_COMMIT;
          else if (load_ok)       state_d = S_WAIT;
          else                    state_d = S_ERR;
        end
      end
      S_WAIT:   if (mem_valid) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the transition so they land registered
  always_comb begin
    go_commit = (state_d == S_COMMIT);
    go_err    = (state_d == S_ERR);
    c_rd      = (state_q == S_IDLE) ? rd : rd_q;
    c_data    = (state_q == S_IDLE) ? src : ext;
    da_d      = go_commit ? c_rd : da_q;
    din_d     = go_commit ? c_data : din_q;
    web_d     = go_commit && (c_rd != 5'd0);
    done_d    = go_commit || go_err;
    err_d     = go_err;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      f3_q   <= '0;
      alo_q  <= '0;
      da_q   <= '0;
      din_q  <= '0;
      web_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && wb_req) begin
        rd_q  <= rd;
        f3_q  <= funct3;
        alo_q <= addr_lo;
      end
      da_q   <= da_d;
      din_q  <= din_d;
      web_q  <= web_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign da      = da_q;
  assign din     = din_q;
  assign web     = web_q;
  assign wb_busy = busy_q;
  assign wb_done = done_q;
  assign wb_err  = err_q;

`ifdef REGFILE_WB_FWD_EN
  logic            fv_q;
  logic [4:0]      frd_q;
  logic [XLEN-1:0] fdat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q   <= 1'b0;
      frd_q  <= '0;
      fdat_q <= '0;
    end else begin
      fv_q   <= web_d;
      frd_q  <= web_d ? da_d : 5'd0;
      fdat_q <= web_d ? din_d : '0;
    end
  end

  assign fwd_valid = fv_q;
  assign fwd_rd    = frd_q;
  assign fwd_data  = fdat_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback.
// Covers sources, load extend, x0, errors, busy and reset.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [4:0]  da;
  logic [31:0] din;
  logic        web;
  logic        wb_busy;
  logic        wb_done;
  logic        wb_err;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int tests = 0;
  int fails = 0;

`ifdef REGFILE_WB_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  regfile_writeback dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_sel(wb_sel),
    .rd(rd), .funct3(funct3),
    .addr_lo(addr_lo),
    .alu_result(alu_result),
    .pc_plus4(pc_plus4), .imm(imm),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .da(da), .din(din), .web(web),
    .wb_busy(wb_busy),
    .wb_done(wb_done),
    .wb_err(wb_err),
    .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [1:0] s,
                     input logic [4:0] r,
                     input logic [2:0] f,
                     input logic [1:0] a);
    wb_req  = 1'b1;
    wb_sel  = s;
    rd      = r;
    funct3  = f;
    addr_lo = a;
    tick();
    wb_req  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_req = 1'b0; wb_sel = 2'b00;
    rd = 5'd0; funct3 = 3'd0; addr_lo = 2'd0;
    alu_result = 32'h12345678;
    pc_plus4 = 32'h44; imm = 32'hABCD0000;
    mem_rdata = 32'h0; mem_valid = 1'b0;
    tick();
    tick();
    chk("rst_web", {31'd0, web}, 32'd0);
    chk("rst_busy", {31'd0, wb_busy}, 32'd0);
    chk("rst_done", {31'd0, wb_done}, 32'd0);
    chk("rst_da", {27'd0, da}, 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_fwd", {31'd0, fwd_valid}, 32'd0);
    rst = 1'b0;
    tick();

    // ALU
    req(2'b00, 5'd3, 3'd0, 2'd0);
    chk("alu_web", {31'd0, web}, 32'd1);
    chk("alu_da", {27'd0, da}, 32'd3);
    chk("alu_din", din, 32'h12345678);
    chk("alu_done", {31'd0, wb_done}, 32'd1);
    chk("alu_busy", {31'd0, wb_busy}, 32'd1);
    chk("alu_fwdv", {31'd0, fwd_valid}, {31'd0, FWD});
    chk("alu_fwdd", fwd_data, FWD ? 32'h12345678 : 32'd0);
    tick();
    chk("alu_web0", {31'd0, web}, 32'd0);
    chk("alu_done0", {31'd0, wb_done}, 32'd0);
    chk("alu_dahold", {27'd0, da}, 32'd3);
    chk("alu_dinhold", din, 32'h12345678);

    // IMM
    req(2'b11, 5'd12, 3'd0, 2'd0);
    chk("imm_din", din, 32'hABCD0000);
    chk("imm_da", {27'd0, da}, 32'd12);
    tick();

    // LB sign extend, valid 3 cycles after request
    mem_rdata = 32'h00800000;
    req(2'b01, 5'd5, 3'b000, 2'd2);
    chk("lb_busy1", {31'd0, wb_busy}, 32'd1);
    chk("lb_web1", {31'd0, web}, 32'd0);
    tick();
    chk("lb_busy2", {31'd0, wb_busy}, 32'd1);
    tick();
    chk("lb_busy3", {31'd0, wb_busy}, 32'd1);
    chk("lb_done3", {31'd0, wb_done}, 32'd0);
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    chk("lb_web", {31'd0, web}, 32'd1);
    chk("lb_din", din, 32'hFFFFFF80);
    chk("lb_da", {27'd0, da}, 32'd5);
    tick();
    chk("lb_web0", {31'd0, web}, 32'd0);
    chk("lb_busy0", {31'd0, wb_busy}, 32'd0);

    // LHU zero extend, minimum latency
    mem_rdata = 32'hBEEF0000;
    mem_valid = 1'b1;
    req(2'b01, 5'd6, 3'b101, 2'd2);
    tick();
    mem_valid = 1'b0;
    chk("lhu_din", din, 32'h0000BEEF);
    chk("lhu_web", {31'd0, web}, 32'd1);
    tick();

    // LH sign extend, low half
    mem_rdata = 32'h1234C001;
    mem_valid = 1'b1;
    req(2'b01, 5'd8, 3'b001, 2'd0);
    tick();
    mem_valid = 1'b0;
    chk("lh_din", din, 32'hFFFFC001);
    tick();

    // LBU byte 3
    mem_rdata = 32'h9A000000;
    mem_valid = 1'b1;
    req(2'b01, 5'd9, 3'b100, 2'd3);
    tick();
    mem_valid = 1'b0;
    chk("lbu_din", din, 32'h0000009A);
    tick();

    // x0 suppression
    req(2'b10, 5'd0, 3'd0, 2'd0);
    chk("x0_done", {31'd0, wb_done}, 32'd1);
    chk("x0_web", {31'd0, web}, 32'd0);
    chk("x0_fwdv", {31'd0, fwd_valid}, 32'd0);
    tick();
    chk("x0_web2", {31'd0, web}, 32'd0);

    // misaligned LW
    req(2'b01, 5'd4, 3'b010, 2'd1);
    chk("lw_err", {31'd0, wb_err}, 32'd1);
    chk("lw_done", {31'd0, wb_done}, 32'd1);
    chk("lw_web", {31'd0, web}, 32'd0);
    tick();
    chk("lw_err0", {31'd0, wb_err}, 32'd0);
    chk("lw_done0", {31'd0, wb_done}, 32'd0);

    // illegal funct3
    req(2'b01, 5'd4, 3'b011, 2'd0);
    chk("f3_err", {31'd0, wb_err}, 32'd1);
    tick();

    // second request during WAIT_MEM is dropped
    req(2'b01, 5'd7, 3'b010, 2'd0);
    alu_result = 32'h55555555;
    req(2'b00, 5'd9, 3'd0, 2'd0);
    chk("dup_web0", {31'd0, web}, 32'd0);
    chk("dup_busy", {31'd0, wb_busy}, 32'd1);
    mem_rdata = 32'hCAFEF00D;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    chk("dup_web", {31'd0, web}, 32'd1);
    chk("dup_da", {27'd0, da}, 32'd7);
    chk("dup_din", din, 32'hCAFEF00D);
    tick();
    chk("dup_web1", {31'd0, web}, 32'd0);
    tick();
    chk("dup_web2", {31'd0, web}, 32'd0);
    chk("dup_idle", {31'd0, wb_busy}, 32'd0);

    // reset mid-load
    req(2'b01, 5'd5, 3'b010, 2'd0);
    chk("mr_busy", {31'd0, wb_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rdata = 32'hFFFFFFFF;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    chk("mr_web", {31'd0, web}, 32'd0);
    chk("mr_done", {31'd0, wb_done}, 32'd0);
    chk("mr_busy0", {31'd0, wb_busy}, 32'd0);
    chk("mr_da", {27'd0, da}, 32'd0);
    chk("mr_din", din, 32'd0);
    tick();
    chk("mr_web2", {31'd0, web}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
